// File: rtl/four_bit_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands with in_valid; the slave returns a registered result with out_valid.
interface four_bit_adder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  s, cout, ovf, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output s, cout, ovf, out_valid
    );
endinterface

// File: rtl/four_bit_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout,s} = a + b + cin, plus a signed-overflow flag.
// Each result appears one clock after the edge on which in_valid was high.
module four_bit_adder #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    four_bit_adder_if.slave bus
);
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_prop;
    logic [WIDTH-1:0] w_gen;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    assign w_carry[0] = bus.cin;

    // One full-adder cell per bit; the carry ripples from the LSB upwards.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign w_prop[gi]    = bus.a[gi] ^ bus.b[gi];
            assign w_gen[gi]     = bus.a[gi] & bus.b[gi];
            assign w_sum[gi]     = w_prop[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = w_gen[gi] | (w_prop[gi] & w_carry[gi]);
        end
    endgenerate

    // Result flops load only on qualified inputs, so anything on a/b/cin
    // while in_valid is low cannot reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s    <= w_sum;
                r_cout <= w_carry[WIDTH];
                r_ovf  <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
            end
        end
    end

    assign bus.s         = r_s;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_four_bit_adder.sv
// Scoreboard bench for four_bit_adder: expected results are queued at drive time and
// popped when out_valid is seen; idle cycles check that the last result is held.
module tb_four_bit_adder;
    typedef struct {
        logic [3:0] s;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   n_txn;
    exp_t sb[$];
    exp_t last_exp;

    four_bit_adder_if #(.WIDTH(4)) bus4 ();
    four_bit_adder_if #(.WIDTH(8)) bus8 ();

    four_bit_adder #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    four_bit_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic cin);
        exp_t       e;
        logic [4:0] t;
        int         r;
        t      = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        r      = int'($signed(a)) + int'($signed(b)) + int'(cin);
        e.s    = t[3:0];
        e.cout = t[4];
        e.ovf  = (r > 7) || (r < -8);
        return e;
    endfunction

    function automatic exp_t mk(input logic [3:0] s, input logic cout, input logic ovf);
        exp_t e;
        e.s    = s;
        e.cout = cout;
        e.ovf  = ovf;
        return e;
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin, input exp_t e);
        @(negedge clk);
        bus4.in_valid = 1'b1;
        bus4.a        = a;
        bus4.b        = b;
        bus4.cin      = cin;
        if (rst_n) sb.push_back(e);
    endtask

    task automatic drive_rand();
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        a   = 4'($urandom);
        b   = 4'($urandom);
        cin = 1'($urandom);
        drive(a, b, cin, model(a, b, cin));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus4.in_valid = 1'b0;
            bus4.a        = (i % 2 == 0) ? 4'bx : 4'($urandom);
            bus4.b        = 4'($urandom);
            bus4.cin      = 1'($urandom);
        end
    endtask

    // Monitor: one step per clock, 1 time unit after the rising edge.
    always begin : monitor
        logic exp_v;
        exp_t e;
        @(posedge clk);
        exp_v = bus4.in_valid & rst_n;
        #1;
        if (!rst_n) begin
            sb.delete();
            last_exp = mk(4'h0, 1'b0, 1'b0);
        end else begin
            check("out_valid", 32'(bus4.out_valid), 32'(exp_v));
            if (bus4.out_valid) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    n_txn++;
                    $display("txn %0d: s=%b cout=%b ovf=%b (exp s=%b cout=%b ovf=%b)",
                             n_txn, bus4.s, bus4.cout, bus4.ovf, e.s, e.cout, e.ovf);
                    check("s",    32'(bus4.s),    32'(e.s));
                    check("cout", 32'(bus4.cout), 32'(e.cout));
                    check("ovf",  32'(bus4.ovf),  32'(e.ovf));
                    last_exp = e;
                end
            end else begin
                check("hold_s",    32'(bus4.s),    32'(last_exp.s));
                check("hold_cout", 32'(bus4.cout), 32'(last_exp.cout));
                check("hold_ovf",  32'(bus4.ovf),  32'(last_exp.ovf));
            end
        end
    end

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        n_txn         = 0;
        last_exp      = mk(4'h0, 1'b0, 1'b0);
        rst_n         = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.a        = 4'h0;
        bus4.b        = 4'h0;
        bus4.cin      = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.a        = 8'h00;
        bus8.b        = 8'h00;
        bus8.cin      = 1'b0;

        #2;
        check("rst_s",         32'(bus4.s),         32'h0);
        check("rst_cout",      32'(bus4.cout),      32'h0);
        check("rst_ovf",       32'(bus4.ovf),       32'h0);
        check("rst_out_valid", 32'(bus4.out_valid), 32'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, back to back.
        drive(4'b0000, 4'b0000, 1'b0, mk(4'b0000, 1'b0, 1'b0));
        drive(4'b1101, 4'b0010, 1'b0, mk(4'b1111, 1'b0, 1'b0));
        drive(4'b1101, 4'b0010, 1'b1, mk(4'b0000, 1'b1, 1'b0));
        drive(4'b1010, 4'b0011, 1'b1, mk(4'b1110, 1'b0, 1'b0));
        drive(4'b1000, 4'b1000, 1'b1, mk(4'b0001, 1'b1, 1'b1));
        drive(4'b1111, 4'b0000, 1'b1, mk(4'b0000, 1'b1, 1'b0));
        drive(4'b0111, 4'b0001, 1'b0, mk(4'b1000, 1'b0, 1'b1));

        // Hold with changing (and unknown) operands.
        idle(3);

        for (int i = 0; i < 40; i++) drive_rand();
        idle(2);
        for (int i = 0; i < 5; i++) drive_rand();

        // Asynchronous reset mid-cycle with a result in flight.
        drive(4'b0111, 4'b0111, 1'b1, mk(4'b1111, 1'b0, 1'b1));
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_s",         32'(bus4.s),         32'h0);
        check("mid_rst_cout",      32'(bus4.cout),      32'h0);
        check("mid_rst_ovf",       32'(bus4.ovf),       32'h0);
        check("mid_rst_out_valid", 32'(bus4.out_valid), 32'h0);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 20; i++) drive_rand();
        idle(3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // WIDTH=8 build: 0xFF + 0x01 wraps to zero with carry out, no signed overflow.
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.a        = 8'hFF;
        bus8.b        = 8'h01;
        bus8.cin      = 1'b0;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.a        = 8'h55;
        #1;
        check("w8_s",         32'(bus8.s),         32'h00);
        check("w8_cout",      32'(bus8.cout),      32'h1);
        check("w8_ovf",       32'(bus8.ovf),       32'h0);
        check("w8_out_valid", 32'(bus8.out_valid), 32'h1);
        @(negedge clk);
        #1;
        check("w8_hold_s",    32'(bus8.s),         32'h00);
        check("w8_pulse",     32'(bus8.out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
